reg_dump_streamer: RTL and testbench

//   Reads the register-file debug taps (x1..x31) and streams a coherent snapshot out as
//   {index, data} beats over a valid/ready interface, for test readback and debug.

---
 rtl/reg_dump_streamer.sv | 81 ++++++++
 tb/tb_reg_dump_streamer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reg_dump_streamer.sv
// reg_dump_streamer: snapshots x1..x31 and streams {idx, data} beats with optional zero-skip and checksum beat
module reg_dump_streamer #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int EMIT_CHECKSUM = 1,
  localparam int IDX_W = $clog2(NUM_REGS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_skip_zero,
  input  logic [(NUM_REGS-1)*DATA_W-1:0] i_xregs,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_W-1:0]            o_data,
  output logic [IDX_W-1:0]             o_idx,
  output logic                         o_is_sum,
  output logic                         o_last,
  output logic                         o_busy,
  output logic                         o_done
);
  typedef enum logic [2:0] {IDLE, SCAN, SEND, SUM, DONE} state_t;
  localparam logic [IDX_W-1:0] MAX = IDX_W'(NUM_REGS - 1);
  localparam state_t EXIT = (EMIT_CHECKSUM != 0) ? SUM : DONE;
  state_t state, nxt;
  logic [DATA_W-1:0] snap [NUM_REGS];
  logic [DATA_W-1:0] sum;
  logic [IDX_W-1:0] idx, last_idx;
  logic skip, at_max, skip_cur, acc_data;
  assign at_max = idx == MAX;
  assign skip_cur = skip && snap[idx] == '0;
  assign acc_data = state == SEND && i_ready;
  always_ff @(posedge i_clk) state <= !i_rst_n ? IDLE : nxt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) snap[i] <= '0;
      idx <= '0;
      sum <= '0;
      skip <= 1'b0;
    end else begin
      if (state == IDLE && i_start) begin
        snap[0] <= '0;
        for (int i = 1; i < NUM_REGS; i++) snap[i] <= i_xregs[(i-1)*DATA_W +: DATA_W];
        skip <= i_skip_zero;
        idx <= '0;
        sum <= '0;
      end
      if (state == SCAN && skip_cur && !at_max) idx <= idx + IDX_W'(1);
      if (acc_data) begin
        sum <= sum + snap[idx];
        if (!at_max) idx <= idx + IDX_W'(1);
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = i_start ? SCAN : IDLE;
      SCAN: nxt = !skip_cur ? SEND : at_max ? EXIT : SCAN;
      SEND: nxt = !i_ready ? SEND : at_max ? EXIT : SCAN;
      SUM:  nxt = i_ready ? DONE : SUM;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // highest index that will be emitted, used to flag the final beat when no checksum follows
  always_comb begin
    last_idx = '0;
    for (int i = 1; i < NUM_REGS; i++) if (snap[i] != '0) last_idx = IDX_W'(i);
    last_idx = skip ? last_idx : MAX;
  end
  always_comb begin
    o_valid = state == SEND || state == SUM;
    o_is_sum = state == SUM;
    o_data = state == SEND ? snap[idx] : state == SUM ? sum : '0;
    o_idx = state == SEND ? idx : '0;
    o_last = state == SUM || (state == SEND && EMIT_CHECKSUM == 0 && idx == last_idx);
    o_busy = state != IDLE;
    o_done = state == DONE;
  end
endmodule

// File: tb/tb_reg_dump_streamer.sv
// tb_reg_dump_streamer: table-driven dumps against checksum and no-checksum instances, plus reset corner cases
module tb_reg_dump_streamer;
  localparam int DW = 32, NR = 32, IW = 5;
  logic clk = 0, rst_n = 0, start = 0, skip = 0, ready = 1;
  logic [(NR-1)*DW-1:0] xregs = '0;
  logic v1, s1, l1, b1, dn1, v0, s0, l0, b0, dn0;
  logic [DW-1:0] d1, d0;
  logic [IW-1:0] i1, i0;
  always #5 clk = ~clk;
  reg_dump_streamer #(.DATA_W(DW), .NUM_REGS(NR), .EMIT_CHECKSUM(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_skip_zero(skip), .i_xregs(xregs),
    .o_valid(v1), .i_ready(ready), .o_data(d1), .o_idx(i1), .o_is_sum(s1), .o_last(l1),
    .o_busy(b1), .o_done(dn1));
  reg_dump_streamer #(.DATA_W(DW), .NUM_REGS(NR), .EMIT_CHECKSUM(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_skip_zero(skip), .i_xregs(xregs),
    .o_valid(v0), .i_ready(ready), .o_data(d0), .o_idx(i0), .o_is_sum(s0), .o_last(l0),
    .o_busy(b0), .o_done(dn0));
  typedef struct {
    string name;
    int kind;
    bit skip;
    bit bp;
    bit coh;
    bit mid;
    int cnt;
    logic [31:0] sum;
  } vec_t;
  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] d;
    logic s;
    logic l;
  } beat_t;
  vec_t tv[9];
  logic [DW-1:0] img [NR];
  beat_t q1[$], q0[$], ex[$];
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic set_img(input int kind);
    img[0] = '0;
    for (int i = 1; i < NR; i++)
      img[i] = kind == 0 ? DW'(i * 32'h11) : kind == 1 ? (i == 5 ? 32'hDEADBEEF : i == 31 ? 32'h1 : 32'h0) :
               kind == 2 ? 32'h0 : 32'hFFFFFFFF;
    for (int i = 1; i < NR; i++) xregs[(i-1)*DW +: DW] = img[i];
  endtask
  task automatic run_vec(input int n);
    int cyc, nb, stall, done1, done0, lat0;
    bit pulsed;
    set_img(tv[n].kind);
    skip = tv[n].skip;
    ready = 1;
    ex.delete(); q1.delete(); q0.delete();
    for (int i = 0; i < NR; i++) if (!tv[n].skip || img[i] != 0) ex.push_back('{IW'(i), img[i], 1'b0, 1'b0});
    cyc = 0; nb = 0; stall = 0; done1 = 0; done0 = 0; lat0 = 0; pulsed = 0;
    @(negedge clk);
    start = 1;
    while (cyc < 300 && !(done1 > 0 && done0 > 0)) begin
      @(negedge clk);
      cyc++;
      start = 0;
      if (tv[n].coh && cyc == 1) xregs = '1;
      if (tv[n].mid && nb == 10 && !pulsed) begin start = 1; pulsed = 1; end
      if (tv[n].bp && nb == 2 && stall < 3 && (stall > 0 || v1)) begin
        ready = 0;
        chk({tv[n].name, "_hold"}, {31'(0), v1, 27'(i1), d1}, {32'd1, 27'd2, img[2]});
        stall++;
      end else ready = 1;
      if (v1 && ready) begin q1.push_back('{i1, d1, s1, l1}); nb++; end
      if (v0 && ready) q0.push_back('{i0, d0, s0, l0});
      if (dn1) done1++;
      if (dn0) begin done0++; lat0 = cyc; end
    end
    ready = 1;
    start = 0;
    repeat (2) begin
      @(negedge clk);
      if (dn1) done1++;
      if (dn0) done0++;
    end
    chk({tv[n].name, "_beats1"}, q1.size(), tv[n].cnt + 1);
    for (int k = 0; k < q1.size() - 1 && k < ex.size(); k++)
      chk({tv[n].name, "_beat1"}, 64'(q1[k]), 64'(ex[k]));
    if (q1.size() > 0) chk({tv[n].name, "_sum"}, 64'(q1[q1.size()-1]), 64'(beat_t'{IW'(0), tv[n].sum, 1'b1, 1'b1}));
    chk({tv[n].name, "_beats0"}, q0.size(), tv[n].cnt);
    for (int k = 0; k < q0.size() && k < ex.size(); k++)
      chk({tv[n].name, "_beat0"}, 64'(q0[k]), 64'(beat_t'{ex[k].idx, ex[k].d, 1'b0, k == tv[n].cnt - 1}));
    chk({tv[n].name, "_done1"}, done1, 1);
    chk({tv[n].name, "_done0"}, done0, 1);
    if (tv[n].cnt == 0) chk({tv[n].name, "_lat0"}, lat0 >= 1 && lat0 <= 33, 1);
    if (tv[n].bp) chk({tv[n].name, "_stalls"}, stall, 3);
  endtask
  initial begin
    int cyc;
    tv[0] = '{"no_skip",      0, 0, 0, 0, 0, 32, 32'h000020F0};
    tv[1] = '{"skip_zero",    1, 1, 0, 0, 0,  2, 32'hDEADBEF0};
    tv[2] = '{"backpressure", 0, 0, 1, 0, 0, 32, 32'h000020F0};
    tv[3] = '{"coherency",    0, 0, 0, 1, 0, 32, 32'h000020F0};
    tv[4] = '{"busy_start",   0, 0, 0, 0, 1, 32, 32'h000020F0};
    tv[5] = '{"sparse_all",   1, 0, 0, 0, 0, 32, 32'hDEADBEF0};
    tv[6] = '{"ones_wrap",    3, 0, 0, 0, 0, 32, 32'hFFFFFFE1};
    tv[7] = '{"skip_x0",      0, 1, 0, 0, 0, 31, 32'h000020F0};
    tv[8] = '{"empty",        2, 1, 0, 0, 0,  0, 32'h00000000};
    repeat (3) @(negedge clk);
    chk("reset1", {v1, s1, l1, b1, dn1, i1, d1}, '0);
    chk("reset0", {v0, s0, l0, b0, dn0, i0, d0}, '0);
    rst_n = 1;
    for (int n = 0; n < 9; n++) run_vec(n);
    set_img(0);
    skip = 0;
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (cyc < 100 && !(v1 && i1 == 5)) begin @(negedge clk); cyc++; end
    chk("mid_reach", {v1, 3'(0), i1, d1}, {1'b1, 8'd5, img[5]});
    rst_n = 0;
    @(negedge clk);
    chk("mid_rst1", {v1, b1, dn1}, 3'b000);
    chk("mid_rst0", {v0, b0, dn0}, 3'b000);
    rst_n = 1;
    @(negedge clk);
    chk("post_rst", {v1, b1, dn1, dn0}, 4'b0000);
    run_vec(0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
